// File: rtl/brick_field.sv
// Playfield occupancy map for the ball stage: brick rows, paddle row, strike clearing,
// score/brick counters and the IDLE/PLAY/WIN/LOSE game state machine.
module brick_field #(
    parameter int BRICK_ROWS = 3,
    parameter int PADDLE_W   = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         ball_step,
    input  logic         paddle_step,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic [3:0]   Ball_rowIndex,
    input  logic [3:0]   Ball_colIndex,
    input  logic [1:0]   Ball_direction,
    output logic [191:0] data,
    output logic [7:0]   score,
    output logic [7:0]   bricks_left,
    output logic [1:0]   game_state,
    output logic         ball_run
);

    localparam int          NB       = BRICK_ROWS * 16;
    localparam logic [3:0]  PAD_MAX  = 4'(16 - PADDLE_W);
    localparam logic [3:0]  PAD_HOME = 4'((16 - PADDLE_W) / 2);
    localparam logic [15:0] PAD_ONES = 16'((1 << PADDLE_W) - 1);
    localparam logic [7:0]  FULL     = 8'(NB);

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, WIN = 2'b10, LOSE = 2'b11} state_t;

    state_t        state, state_nx;
    logic [NB-1:0] bricks, bricks_nx, clr;
    logic [3:0]    paddle, paddle_nx;
    logic [7:0]    score_q, score_nx, left_q, left_nx;
    logic [255:0]  map_ext;
    logic [4:0]    r_v, c_h;
    logic [7:0]    v_idx, h_idx, d_idx;
    logic          v_hit, h_hit, d_hit, d_sel, strike_en, do_load, move_ok;
    logic [1:0]    n_clr;
    logic [8:0]    score_sum, left_diff;

    // UP/DOWN selects the row offset; RIGHT travels toward lower columns, LEFT toward higher.
    assign r_v     = Ball_direction[1] ? {1'b0, Ball_rowIndex} + 5'd1 : {1'b0, Ball_rowIndex} - 5'd1;
    assign c_h     = Ball_direction[0] ? {1'b0, Ball_colIndex} + 5'd1 : {1'b0, Ball_colIndex} - 5'd1;
    assign map_ext = 256'(bricks);
    assign v_idx   = {r_v[3:0], Ball_colIndex};
    assign h_idx   = {Ball_rowIndex, c_h[3:0]};
    assign d_idx   = {r_v[3:0], c_h[3:0]};

    // Underflow wraps to 31 in 5 bits, so the upper-bound tests also reject negative targets.
    assign v_hit = (r_v < 5'(BRICK_ROWS)) && map_ext[v_idx];
    assign h_hit = (Ball_rowIndex < 4'(BRICK_ROWS)) && (c_h < 5'd16) && map_ext[h_idx];
    assign d_hit = (r_v < 5'(BRICK_ROWS)) && (c_h < 5'd16) && map_ext[d_idx];
    assign d_sel = d_hit && !v_hit && !h_hit;
    assign n_clr = {1'b0, v_hit} + {1'b0, h_hit} + {1'b0, d_sel};

    always_comb begin
        for (int unsigned i = 0; i < NB; i++) begin
            clr[i] = (v_hit && v_idx == 8'(i)) || (h_hit && h_idx == 8'(i)) || (d_sel && d_idx == 8'(i));
        end
    end

    assign score_sum = {1'b0, score_q} + 9'(n_clr);
    assign left_diff = {1'b0, left_q} - 9'(n_clr);
    assign move_ok   = paddle_step && (btn_left ^ btn_right) && (state == IDLE || state == PLAY);

    always_comb begin
        state_nx  = state;
        bricks_nx = bricks;
        paddle_nx = paddle;
        score_nx  = score_q;
        left_nx   = left_q;
        strike_en = 1'b0;
        do_load   = 1'b0;
        case (state)
            IDLE: if (start) state_nx = PLAY;
            PLAY: begin
                if (ball_step && Ball_rowIndex == 4'd11) begin
                    state_nx = LOSE;
                end else begin
                    if (left_q == '0) state_nx = WIN;
                    strike_en = ball_step;
                end
            end
            WIN, LOSE: if (start) do_load = 1'b1;
            default: ;
        endcase
        if (strike_en) begin
            bricks_nx = bricks & ~clr;
            score_nx  = score_sum[8] ? 8'hFF : score_sum[7:0];
            left_nx   = left_diff[8] ? 8'h00 : left_diff[7:0];
        end
        if (move_ok) begin
            if (btn_left && paddle < PAD_MAX) paddle_nx = paddle + 4'd1;
            if (btn_right && paddle != 4'd0)  paddle_nx = paddle - 4'd1;
        end
        if (do_load) begin
            state_nx  = IDLE;
            bricks_nx = '1;
            paddle_nx = PAD_HOME;
            score_nx  = '0;
            left_nx   = FULL;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            bricks  <= '1;
            paddle  <= PAD_HOME;
            score_q <= '0;
            left_q  <= FULL;
        end else begin
            state   <= state_nx;
            bricks  <= bricks_nx;
            paddle  <= paddle_nx;
            score_q <= score_nx;
            left_q  <= left_nx;
        end
    end

    always_comb begin
        data           = '0;
        data[NB-1:0]   = bricks;
        data[176 +: 16] = PAD_ONES << paddle;
    end

    assign score       = score_q;
    assign bricks_left = left_q;
    assign game_state  = state;
    assign ball_run    = (state == PLAY);

endmodule

// File: tb/tb_brick_field.sv
// Scoreboard bench for brick_field: a cell-level game model predicts every cycle for a
// default instance and a single-brick-row instance; a monitor compares on the falling edge.
module tb_brick_field;

    logic         clock = 1'b0;
    logic         reset, start, ball_step, paddle_step, btn_left, btn_right;
    logic [3:0]   row, col;
    logic [1:0]   dir;
    logic [191:0] data0, data1;
    logic [7:0]   score0, score1, left0, left1;
    logic [1:0]   gs0, gs1;
    logic         run0, run1;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        bit [191:0] br;
        int pad;
        int sc;
        int left;
        int st;
    } model_t;

    typedef struct {
        bit [191:0] d;
        int sc;
        int left;
        int st;
        bit run;
    } exp_t;

    model_t m0, m1;
    exp_t   q0[$], q1[$];

    always #5 clock = ~clock;

    brick_field dut (
        .clock(clock), .reset(reset), .start(start), .ball_step(ball_step),
        .paddle_step(paddle_step), .btn_left(btn_left), .btn_right(btn_right),
        .Ball_rowIndex(row), .Ball_colIndex(col), .Ball_direction(dir),
        .data(data0), .score(score0), .bricks_left(left0), .game_state(gs0), .ball_run(run0)
    );

    brick_field #(.BRICK_ROWS(1), .PADDLE_W(2)) dut1 (
        .clock(clock), .reset(reset), .start(start), .ball_step(ball_step),
        .paddle_step(paddle_step), .btn_left(btn_left), .btn_right(btn_right),
        .Ball_rowIndex(row), .Ball_colIndex(col), .Ball_direction(dir),
        .data(data1), .score(score1), .bricks_left(left1), .game_state(gs1), .ball_run(run1)
    );

    function automatic model_t load(int rows, int pw);
        model_t m;
        m.br = '0;
        for (int i = 0; i < rows * 16; i++) m.br[i] = 1'b1;
        m.pad  = (16 - pw) / 2;
        m.sc   = 0;
        m.left = rows * 16;
        m.st   = 0;
        return m;
    endfunction

    function automatic bit brick_at(model_t m, int rows, int r, int c);
        if (r < 0 || r > 11 || c < 0 || c > 15 || r >= rows) return 1'b0;
        return m.br[r * 16 + c];
    endfunction

    function automatic model_t step(model_t m, int rows, int pw, bit rs, bit st, bit bs,
                                    bit ps, bit bl, bit bt, int r, int c, int d);
        model_t n = m;
        int dr = d[1] ? 1 : -1;
        int dc = d[0] ? 1 : -1;
        int cnt = 0;
        if (!rs) return load(rows, pw);
        case (m.st)
            0: if (st) n.st = 1;
            1: begin
                if (bs && r == 11) n.st = 3;
                else begin
                    if (m.left == 0) n.st = 2;
                    if (bs) begin
                        if (brick_at(m, rows, r + dr, c)) begin n.br[(r + dr) * 16 + c] = 1'b0; cnt++; end
                        if (brick_at(m, rows, r, c + dc)) begin n.br[r * 16 + c + dc] = 1'b0; cnt++; end
                        if (cnt == 0 && brick_at(m, rows, r + dr, c + dc)) begin
                            n.br[(r + dr) * 16 + c + dc] = 1'b0;
                            cnt++;
                        end
                        n.sc   = (m.sc + cnt > 255) ? 255 : m.sc + cnt;
                        n.left = (m.left - cnt < 0) ? 0 : m.left - cnt;
                    end
                end
            end
            default: if (st) return load(rows, pw);
        endcase
        if (m.st <= 1 && ps && (bl != bt)) begin
            if (bl) n.pad = (m.pad + 1 > 16 - pw) ? 16 - pw : m.pad + 1;
            else    n.pad = (m.pad == 0) ? 0 : m.pad - 1;
        end
        return n;
    endfunction

    function automatic exp_t expect_of(model_t m, int pw);
        exp_t e;
        e.d = m.br;
        for (int k = 0; k < pw; k++) e.d[176 + m.pad + k] = 1'b1;
        e.sc   = m.sc;
        e.left = m.left;
        e.st   = m.st;
        e.run  = (m.st == 1);
        return e;
    endfunction

    task automatic drive(input bit rs, input bit st, input bit bs, input bit ps,
                         input bit bl, input bit bt, input int r, input int c, input int d);
        reset = rs; start = st; ball_step = bs; paddle_step = ps;
        btn_left = bl; btn_right = bt;
        row = 4'(r); col = 4'(c); dir = 2'(d);
        @(posedge clock);
        m0 = step(m0, 3, 4, rs, st, bs, ps, bl, bt, r, c, d);
        m1 = step(m1, 1, 2, rs, st, bs, ps, bl, bt, r, c, d);
        q0.push_back(expect_of(m0, 4));
        q1.push_back(expect_of(m1, 2));
        @(negedge clock);
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [191:0] d,
                           input logic [7:0] s, input logic [7:0] l, input logic [1:0] g, input logic rn);
        vectors++;
        if (d !== e.d || s !== 8'(e.sc) || l !== 8'(e.left) || g !== 2'(e.st) || rn !== e.run) begin
            fails++;
            $display("FAIL %s t=%0t data got %h want %h score got %0d want %0d left got %0d want %0d state got %0d want %0d run got %0b want %0b",
                     tag, $time, d, e.d, s, e.sc, l, e.left, g, e.st, rn, e.run);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            compare("main", e, data0, score0, left0, gs0, run0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            compare("one_row", e, data1, score1, left1, gs1, run1);
        end
    end

    initial begin
        reset = 1'b0; start = 1'b0; ball_step = 1'b0; paddle_step = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; row = '0; col = '0; dir = '0;
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // paddle clamp at the high end, then both buttons held
        for (int i = 0; i < 12; i++) drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++)  drive(1, 0, 0, 1, 1, 1, 0, 0, 0);
        // vertical strike, then diagonal fallback at the same ball position
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 3, 5, 0);
        drive(1, 0, 0, 0, 0, 0, 3, 5, 0);
        drive(1, 0, 1, 0, 0, 0, 3, 5, 0);
        drive(1, 0, 0, 0, 0, 0, 3, 5, 0);
        // lose with a simultaneous start (ignored), then restart to IDLE
        drive(1, 1, 1, 1, 0, 1, 11, 7, 2);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // sweep row 0 so the single-row instance runs out of bricks and wins
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 16; c++) begin
            drive(1, 0, 1, 0, 0, 0, 1, c, 0);
            drive(1, 0, 0, 1, 0, 1, 1, c, 0);
        end
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // randomized play
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
                  r, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain pending got %0d/%0d want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
